// File: rtl/inflight_tag_queue_if.sv
// Bundle between the issue/writeback control and the in-flight tag queue.
// The queue side uses the slave modport; the controller side uses master.
interface inflight_tag_queue_if #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic                              i_flush;
   logic                              i_alloc_valid;
   logic [WIDTH-1:0]                  i_alloc_tag;
   logic                              o_alloc_ready;
   logic                              i_retire;
   logic [0:DEPTH-1][WIDTH-1:0]       o_tags;
   logic [CntW-1:0]                   o_count;
   logic                              o_empty;
   logic [WIDTH-1:0]                  o_head_tag;

   modport master (
      output i_flush, i_alloc_valid, i_alloc_tag, i_retire,
      input  o_alloc_ready, o_tags, o_count, o_empty, o_head_tag
   );

   modport slave (
      input  i_flush, i_alloc_valid, i_alloc_tag, i_retire,
      output o_alloc_ready, o_tags, o_count, o_empty, o_head_tag
   );
endinterface

// File: rtl/inflight_tag_queue.sv
// In-order queue of destination tags in flight between issue and writeback.
// Every physical slot is exposed for a valid-less N-way hazard matcher.
module inflight_tag_queue #(
   parameter int unsigned     WIDTH      = 5,
   parameter int unsigned     DEPTH      = 4,
   parameter logic [WIDTH-1:0] NULL_VALUE = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   inflight_tag_queue_if.slave   io_bus
);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [PtrW-1:0]  r_head;
   logic [PtrW-1:0]  r_tail;
   logic [CntW-1:0]  r_count;
   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_tag [DEPTH];

   logic w_ready;
   logic w_alloc;
   logic w_retire;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_comb begin
      w_ready  = (r_count != CntW'(DEPTH));
      w_alloc  = io_bus.i_alloc_valid && w_ready;
      w_retire = io_bus.i_retire && (r_count != '0);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || io_bus.i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         if (w_alloc) begin
            r_tag[r_tail]   <= io_bus.i_alloc_tag;
            r_valid[r_tail] <= 1'b1;
            r_tail          <= ptr_inc(r_tail);
         end
         if (w_retire) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= ptr_inc(r_head);
         end
         case ({w_alloc, w_retire})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Empty slots read as NULL_VALUE so the matcher never sees a stale hit.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         io_bus.o_tags[i] = r_valid[i] ? r_tag[i] : NULL_VALUE;
      end
      io_bus.o_head_tag    = r_valid[r_head] ? r_tag[r_head] : NULL_VALUE;
      io_bus.o_count       = r_count;
      io_bus.o_empty       = (r_count == '0);
      io_bus.o_alloc_ready = w_ready;
   end
endmodule

// File: tb/tb_inflight_tag_queue.sv
// Directed plus random stimulus for inflight_tag_queue, checked every cycle
// against a slot-level model of the queue.
module tb_inflight_tag_queue;
   localparam int unsigned WIDTH = 5;
   localparam int unsigned DEPTH = 4;
   localparam int          NULLV = 0;

   logic clk;
   logic rst_n;

   inflight_tag_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   inflight_tag_queue #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .NULL_VALUE (5'(NULLV))
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // Model: physical slots, oldest index and occupancy.
   int m_tag   [DEPTH];
   bit m_valid [DEPTH];
   int m_head;
   int m_count;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_head  = 0;
      m_count = 0;
   endtask

   task automatic model_step(input bit rn, input bit fl, input bit av, input int t,
                             input bit rt);
      int  tail;
      bit  acc;
      bit  ret;
      if (!rn || fl) begin
         model_clear();
         return;
      end
      tail = (m_head + m_count) % DEPTH;
      acc  = av && (m_count < DEPTH);
      ret  = rt && (m_count > 0);
      if (ret) begin
         m_valid[m_head] = 1'b0;
         m_head  = (m_head + 1) % DEPTH;
         m_count = m_count - 1;
      end
      if (acc) begin
         m_tag[tail]   = t;
         m_valid[tail] = 1'b1;
         m_count       = m_count + 1;
      end
   endtask

   task automatic compare_model(input string name);
      check({name, ":count"}, 32'(bus.o_count), 32'(m_count));
      check({name, ":empty"}, 32'(bus.o_empty), 32'(m_count == 0));
      check({name, ":ready"}, 32'(bus.o_alloc_ready), 32'(m_count != DEPTH));
      check({name, ":head"}, 32'(bus.o_head_tag), 32'(m_count == 0 ? NULLV : m_tag[m_head]));
      for (int i = 0; i < DEPTH; i++)
         check($sformatf("%s:tag%0d", name, i), 32'(bus.o_tags[i]),
               32'(m_valid[i] ? m_tag[i] : NULLV));
   endtask

   task automatic check_tags(input string name, input int a, input int b, input int c,
                             input int d);
      check({name, ":s0"}, 32'(bus.o_tags[0]), 32'(a));
      check({name, ":s1"}, 32'(bus.o_tags[1]), 32'(b));
      check({name, ":s2"}, 32'(bus.o_tags[2]), 32'(c));
      check({name, ":s3"}, 32'(bus.o_tags[3]), 32'(d));
   endtask

   // One clock: drive, clock, update the model, then sample 1 time unit later.
   task automatic step(input string name, input bit rn, input bit fl, input bit av,
                       input int t, input bit rt);
      rst_n             = rn;
      bus.i_flush       = fl;
      bus.i_alloc_valid = av;
      bus.i_alloc_tag   = 5'(t);
      bus.i_retire      = rt;
      @(posedge clk);
      model_step(rn, fl, av, t, rt);
      #1;
      rst_n             = 1'b1;
      bus.i_flush       = 1'b0;
      bus.i_alloc_valid = 1'b0;
      bus.i_retire      = 1'b0;
      compare_model(name);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_clear();
      rst_n             = 1'b0;
      bus.i_flush       = 1'b0;
      bus.i_alloc_valid = 1'b0;
      bus.i_alloc_tag   = '0;
      bus.i_retire      = 1'b0;
      @(negedge clk);

      // Reset and fill
      step("reset", 0, 0, 0, 0, 0);
      check("reset_empty", 32'(bus.o_empty), 32'd1);
      check("reset_ready", 32'(bus.o_alloc_ready), 32'd1);
      check_tags("reset_tags", 0, 0, 0, 0);
      step("fill3", 1, 0, 1, 3, 0);
      step("fill7", 1, 0, 1, 7, 0);
      step("fill9", 1, 0, 1, 9, 0);
      step("fill12", 1, 0, 1, 12, 0);
      check_tags("full_tags", 3, 7, 9, 12);
      check("full_count", 32'(bus.o_count), 32'd4);
      check("full_ready", 32'(bus.o_alloc_ready), 32'd0);
      step("refuse15", 1, 0, 1, 15, 0);
      check_tags("refuse_tags", 3, 7, 9, 12);

      // Full with alloc and retire together: only retire fires
      step("full_ar", 1, 0, 1, 15, 1);
      check_tags("full_ar_tags", 0, 7, 9, 12);
      check("full_ar_count", 32'(bus.o_count), 32'd3);
      step("wrap15", 1, 0, 1, 15, 0);
      check_tags("wrap_tags", 15, 7, 9, 12);

      // Simultaneous alloc and retire mid-occupancy
      step("rst2", 0, 0, 0, 0, 0);
      step("a5", 1, 0, 1, 5, 0);
      step("a6", 1, 0, 1, 6, 0);
      step("a8r", 1, 0, 1, 8, 1);
      check_tags("mid_tags", 0, 6, 8, 0);
      check("mid_count", 32'(bus.o_count), 32'd2);
      check("mid_head", 32'(bus.o_head_tag), 32'd6);

      // Empty corner cases
      step("rst3", 0, 0, 0, 0, 0);
      step("ret_empty", 1, 0, 0, 0, 1);
      check("ret_empty_count", 32'(bus.o_count), 32'd0);
      step("alloc0", 1, 0, 1, 0, 0);
      check("alloc0_count", 32'(bus.o_count), 32'd1);
      check("alloc0_empty", 32'(bus.o_empty), 32'd0);
      check_tags("alloc0_tags", 0, 0, 0, 0);

      // Flush priority
      step("rst4", 0, 0, 0, 0, 0);
      step("f1", 1, 0, 1, 1, 0);
      step("f2", 1, 0, 1, 2, 0);
      step("f3", 1, 0, 1, 3, 0);
      step("flush", 1, 1, 1, 4, 1);
      check("flush_count", 32'(bus.o_count), 32'd0);
      check_tags("flush_tags", 0, 0, 0, 0);
      step("post_flush4", 1, 0, 1, 4, 0);
      check_tags("post_flush_tags", 4, 0, 0, 0);

      // Reset mid-operation
      step("r1", 1, 0, 1, 11, 0);
      step("rst_mid", 0, 0, 1, 9, 0);
      check("rst_mid_count", 32'(bus.o_count), 32'd0);
      check_tags("rst_mid_tags", 0, 0, 0, 0);
      step("resume9", 1, 0, 1, 9, 0);
      check_tags("resume_tags", 9, 0, 0, 0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         step("rand", ($urandom_range(0, 49) != 0), ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 2) != 0), int'($urandom_range(0, 31)),
              ($urandom_range(0, 1) == 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
